// File: rtl/layer2_generator_pkg.sv
// Shared constants, FSM state encoding and the Q8.8 saturation helper
// for the second generator fully-connected layer.
package layer2_generator_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned N_IN   = 256;
    localparam int unsigned N_OUT  = 256;
    localparam int unsigned Q_FRAC = 8;
    localparam int unsigned ACC_W  = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    // Clamp a rescaled accumulator value to the signed 16-bit range.
    function automatic logic [DW-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic [DW-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DW-1:0];
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/layer2_generator_rom.sv
// Synchronous weight and bias ROMs for layer2_generator; one-cycle read
// latency, contents fixed at elaboration through the init parameters.
module layer2_generator_rom
    import layer2_generator_pkg::*;
#(
    parameter int unsigned   WDEPTH = N_OUT * N_IN,
    parameter int unsigned   BDEPTH = N_OUT,
    parameter int unsigned   AW     = (WDEPTH > 1) ? $clog2(WDEPTH) : 1,
    parameter int unsigned   BW     = (BDEPTH > 1) ? $clog2(BDEPTH) : 1,
    parameter logic [DW-1:0] W_INIT [WDEPTH] = '{default: '0},
    parameter logic [DW-1:0] B_INIT [BDEPTH] = '{default: '0}
) (
    input  logic          clk,
    input  logic [AW-1:0] w_addr_i,
    input  logic [BW-1:0] b_addr_i,
    output logic [DW-1:0] w_data_o,
    output logic [DW-1:0] b_data_o
);

    logic [DW-1:0] w_data_q;
    logic [DW-1:0] b_data_q;

    always_ff @(posedge clk) begin
        w_data_q <= W_INIT[w_addr_i];
        b_data_q <= B_INIT[b_addr_i];
    end

    assign w_data_o = w_data_q;
    assign b_data_o = b_data_q;

endmodule

// File: rtl/layer2_generator.sv
// Time-multiplexed fully-connected layer: one signed MAC per clock over
// a latched input vector, per-neuron bias add, rescale and saturation.
module layer2_generator
    import layer2_generator_pkg::*;
#(
    parameter int unsigned   NUM_IN  = N_IN,
    parameter int unsigned   NUM_OUT = N_OUT,
    parameter logic [DW-1:0] W_INIT [NUM_OUT*NUM_IN] = '{default: '0},
    parameter logic [DW-1:0] B_INIT [NUM_OUT]        = '{default: '0}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DW*NUM_IN-1:0]  flat_input_flat,
    output logic [DW*NUM_OUT-1:0] flat_output_flat,
    output logic                  done
);

    localparam int unsigned IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned NW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned AW = (NUM_OUT * NUM_IN > 1) ? $clog2(NUM_OUT * NUM_IN) : 1;
    localparam int unsigned PW = 2 * DW;
    localparam logic [IW-1:0] I_LAST = IW'(NUM_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_OUT - 1);

    state_e                   state_q;
    logic                     done_q;
    logic [DW*NUM_IN-1:0]     x_q;
    logic [DW*NUM_OUT-1:0]    out_q;
    logic [NW-1:0]            n_q;
    logic [IW-1:0]            i_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [DW-1:0]            x_sel_q;

    logic [AW-1:0]            w_addr;
    logic [DW-1:0]            w_rd;
    logic [DW-1:0]            b_rd;
    logic [DW-1:0]            x_word;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  scaled;

    assign w_addr = AW'(int'(n_q) * NUM_IN + int'(i_q));
    assign x_word = x_q[int'(i_q) * DW +: DW];

    layer2_generator_rom #(
        .WDEPTH (NUM_OUT * NUM_IN),
        .BDEPTH (NUM_OUT),
        .AW     (AW),
        .BW     (NW),
        .W_INIT (W_INIT),
        .B_INIT (B_INIT)
    ) u_rom (
        .clk      (clk),
        .w_addr_i (w_addr),
        .b_addr_i (n_q),
        .w_data_o (w_rd),
        .b_data_o (b_rd)
    );

    // ROM word and x_sel_q both lag the issued index by one cycle, so they pair up.
    assign prod     = PW'($signed(w_rd)) * PW'($signed(x_sel_q));
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'($signed(b_rd)) <<< Q_FRAC;
    assign sum      = acc_q + bias_ext;
    assign scaled   = sum >>> Q_FRAC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            x_q     <= '0;
            out_q   <= '0;
            n_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            x_sel_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_q     <= flat_input_flat;
                        n_q     <= '0;
                        i_q     <= '0;
                        acc_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_MAC;
                end
                ST_MAC: begin
                    x_sel_q <= x_word;
                    if (i_q != '0) begin
                        acc_q <= acc_q + prod_ext;
                    end
                    if (i_q == I_LAST) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    acc_q   <= acc_q + prod_ext;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    out_q[int'(n_q) * DW +: DW] <= sat16(scaled);
                    acc_q <= '0;
                    i_q   <= '0;
                    if (n_q == N_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        n_q     <= n_q + 1'b1;
                        state_q <= ST_MAC;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign flat_output_flat = out_q;
    assign done             = done_q;

endmodule

// File: tb/tb_layer2_generator.sv
// Scoreboard bench for layer2_generator using two reduced-size instances:
// a 4x4 layer with mixed weights and a 4x2 layer with saturating weights.
module tb_layer2_generator;

    localparam int unsigned NI   = 4;
    localparam int unsigned NO_A = 4;
    localparam int unsigned NO_S = 2;
    localparam int LAT_A = 1 + NO_A * (NI + 2);
    localparam int LAT_S = 1 + NO_S * (NI + 2);

    // Row n holds W[n][0..3]: (1, 2, -1, 0.5) (0.25, 0, 1, -2) (max x4) (-128, 1/256, 1, 0)
    localparam logic [15:0] W_A [16] = '{
        16'h0100, 16'h0200, 16'hFF00, 16'h0080,
        16'h0040, 16'h0000, 16'h0100, 16'hFE00,
        16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
        16'h8000, 16'h0001, 16'h0100, 16'h0000
    };
    localparam logic [15:0] B_A [4] = '{16'h0100, 16'hFF80, 16'h0000, 16'h0010};
    localparam logic [15:0] W_S [8] = '{default: 16'h7FFF};
    localparam logic [15:0] B_S [2] = '{default: 16'h7FFF};

    localparam logic [63:0] X_ZERO = 64'h0;
    localparam logic [63:0] E_ZERO = {16'h0010, 16'h0000, 16'hFF80, 16'h0100};
    localparam logic [63:0] X_UNIT = {16'h0000, 16'h0000, 16'h0000, 16'h0100};
    localparam logic [63:0] E_UNIT = {16'h8010, 16'h7FFF, 16'hFFC0, 16'h0200};
    localparam logic [63:0] X_MIX  = {16'h0400, 16'h0100, 16'h0200, 16'h0100};
    localparam logic [63:0] E_MIX  = {16'h8112, 16'h7FFF, 16'hF8C0, 16'h0700};
    localparam logic [63:0] X_NEG  = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [63:0] E_NEG  = {16'h0010, 16'hFF80, 16'hFF82, 16'h00FF};
    localparam logic [63:0] X_PMAX = {4{16'h7FFF}};
    localparam logic [63:0] E_PMAX = {32'h0, 16'h7FFF, 16'h7FFF};
    localparam logic [63:0] X_NMAX = {4{16'h8001}};
    localparam logic [63:0] E_NMAX = {32'h0, 16'h8000, 16'h8000};

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_s;
    logic        done_a, done_s;
    logic [63:0] x_a, x_s, out_a;
    logic [31:0] out_s;

    logic [63:0] q_a [$];
    logic [31:0] q_s [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer2_generator #(.NUM_IN(NI), .NUM_OUT(NO_A), .W_INIT(W_A), .B_INIT(B_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .flat_input_flat(x_a),
        .flat_output_flat(out_a), .done(done_a)
    );

    layer2_generator #(.NUM_IN(NI), .NUM_OUT(NO_S), .W_INIT(W_S), .B_INIT(B_S)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .flat_input_flat(x_s),
        .flat_output_flat(out_s), .done(done_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the expected vector whenever a done rising edge appears.
    initial begin : mon_a
        logic prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a.unexpected_done: got done=1 expected no result");
                end else begin
                    e = q_a.pop_front();
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("a.out[%0d]", k), 64'(out_a[k*16 +: 16]), 64'(e[k*16 +: 16]));
                end
            end
            prev = done_a;
        end
    end

    initial begin : mon_s
        logic prev;
        logic [31:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_s && !prev) begin
                if (q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s.unexpected_done: got done=1 expected no result");
                end else begin
                    e = q_s.pop_front();
                    for (int k = 0; k < 2; k++)
                        chk($sformatf("s.out[%0d]", k), 64'(out_s[k*16 +: 16]), 64'(e[k*16 +: 16]));
                end
            end
            prev = done_s;
        end
    end

    task automatic run(input bit sel, input logic [63:0] x, input logic [63:0] exp, input bit poke);
        int    cyc;
        int    lat;
        logic  d;
        string pfx;
        cyc = 0;
        lat = sel ? LAT_S : LAT_A;
        pfx = sel ? "s" : "a";
        if (sel) begin
            x_s = x;
            q_s.push_back(exp[31:0]);
        end else begin
            x_a = x;
            q_a.push_back(exp);
        end
        @(negedge clk);
        if (sel) start_s = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_s = 1'b0;
        d = sel ? done_s : done_a;
        chk({pfx, ".done_drop"}, 64'(d), 64'd0);
        while (!d && cyc < 4 * lat) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 8) begin
                start_a = 1'b1;
                x_a     = ~x_a;
            end
            if (poke && cyc == 9) start_a = 1'b0;
            d = sel ? done_s : done_a;
        end
        chk({pfx, ".latency"}, 64'(cyc), 64'(lat));
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_s = 1'b0;
        x_a     = '0;
        x_s     = '0;
        #1;
        chk("reset.done_a", 64'(done_a), 64'd0);
        chk("reset.out_a", out_a, 64'd0);
        chk("reset.done_s", 64'(done_s), 64'd0);
        chk("reset.out_s", 64'(out_s), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(1'b0, X_ZERO, E_ZERO, 1'b0);
        run(1'b0, X_UNIT, E_UNIT, 1'b0);
        run(1'b0, X_MIX, E_MIX, 1'b1);

        // Abort a run part-way through; outputs already hold the previous result.
        x_a = X_MIX;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.done", 64'(done_a), 64'd0);
        chk("midrst.out", out_a, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, X_ZERO, E_ZERO, 1'b0);
        run(1'b0, X_NEG, E_NEG, 1'b0);
        run(1'b1, X_PMAX, E_PMAX, 1'b0);
        run(1'b1, X_NMAX, E_NMAX, 1'b0);

        repeat (3) @(posedge clk);
        chk("a.pending", 64'(q_a.size()), 64'd0);
        chk("s.pending", 64'(q_s.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
